// File: rtl/isqrt_rr_arbiter_if.sv
// isqrt_rr_arbiter_if: bus between requesters, the shared isqrt core and the arbiter
//   req_vld/req_x/req_rdy : per-requester request handshake, operand i at req_x[i*W +: W]
//   sq_x_vld/sq_x         : operand issued to the isqrt core
//   sq_y_vld/sq_y         : result returned by the isqrt core
//   rsp_vld/rsp_y/rsp_id  : one-hot result valid, result value and owning requester
//   in_flight/tag_err     : outstanding-op count and sticky tag/valid disagreement flag
//   master = requesters + isqrt core side, slave = arbiter side
interface isqrt_rr_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int LATENCY = 8
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(LATENCY + 3);
    logic [N_REQ-1:0]   req_vld;
    logic [N_REQ*W-1:0] req_x;
    logic [N_REQ-1:0]   req_rdy;
    logic               sq_x_vld;
    logic [W-1:0]       sq_x;
    logic               sq_y_vld;
    logic [W-1:0]       sq_y;
    logic [N_REQ-1:0]   rsp_vld;
    logic [W-1:0]       rsp_y;
    logic [IDW-1:0]     rsp_id;
    logic [CW-1:0]      in_flight;
    logic               tag_err;
    modport master (
        output req_vld, req_x, sq_y_vld, sq_y,
        input  req_rdy, sq_x_vld, sq_x, rsp_vld, rsp_y, rsp_id, in_flight, tag_err
    );
    modport slave (
        input  req_vld, req_x, sq_y_vld, sq_y,
        output req_rdy, sq_x_vld, sq_x, rsp_vld, rsp_y, rsp_id, in_flight, tag_err
    );
endinterface

// File: rtl/isqrt_rr_arbiter.sv
// isqrt_rr_arbiter: round-robin share of one pipelined isqrt core among N_REQ requesters
//   clk : clock, all logic on posedge
//   rst : synchronous reset, active-low (rst==0 resets)
//   bus : isqrt_rr_arbiter_if slave modport (requests, isqrt issue/return, responses, status)
module isqrt_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int LATENCY = 8
) (
    input logic clk,
    input logic rst,
    isqrt_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(LATENCY + 3);
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gid;
    logic [IDW-1:0]     sq_id;
    logic               hs;
    logic               ret;
    logic [LATENCY-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [LATENCY];
    // Search ptr, ptr+1, ... mod N_REQ; the first set request wins. Held off in reset.
    always_comb begin
        hs  = 1'b0;
        gid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hs && bus.req_vld[(int'(ptr) + k) % N_REQ]) begin
                hs  = 1'b1;
                gid = IDW'((int'(ptr) + k) % N_REQ);
            end
        end
        hs = hs & rst;
    end
    assign bus.req_rdy = hs ? N_REQ'(1) << gid : '0;
    // Tag pipe output lines up with sq_y_vld; a result returns only when both agree.
    assign ret = tag_vld[LATENCY-1] & bus.sq_y_vld;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr           <= '0;
            sq_id         <= '0;
            tag_vld       <= '0;
            bus.sq_x_vld  <= 1'b0;
            bus.sq_x      <= '0;
            bus.rsp_vld   <= '0;
            bus.rsp_y     <= '0;
            bus.rsp_id    <= '0;
            bus.in_flight <= '0;
            bus.tag_err   <= 1'b0;
        end else begin
            bus.sq_x_vld <= hs;
            if (hs) begin
                ptr      <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + 1'b1;
                bus.sq_x <= bus.req_x[gid*W +: W];
                sq_id    <= gid;
            end
            tag_vld[0] <= bus.sq_x_vld;
            tag_id[0]  <= sq_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            bus.rsp_vld <= ret ? N_REQ'(1) << tag_id[LATENCY-1] : '0;
            if (ret) begin
                bus.rsp_y  <= bus.sq_y;
                bus.rsp_id <= tag_id[LATENCY-1];
            end
            if (tag_vld[LATENCY-1] != bus.sq_y_vld)
                bus.tag_err <= 1'b1;
            // An op stays counted through the cycle its response is shown on rsp_*.
            bus.in_flight <= bus.in_flight + CW'(hs) - CW'(|bus.rsp_vld);
        end
    end
endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// tb_isqrt_rr_arbiter: randomized + directed check of isqrt_rr_arbiter against a transaction-level model
module tb_isqrt_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic force_vld = 1'b0;
    logic chk_en = 1'b0;
    int nchk = 0;
    int nerr = 0;
    always #5 clk = ~clk;
    isqrt_rr_arbiter_if #(.N_REQ(N), .W(W), .LATENCY(L)) bus ();
    isqrt_rr_arbiter #(.N_REQ(N), .W(W), .LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        longint r = 0;
        for (int b = 15; b >= 0; b--) begin
            longint t = r | (longint'(1) << b);
            if (t * t <= longint'({32'b0, x})) r = t;
        end
        return W'(r);
    endfunction
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // isqrt core stand-in: fixed latency L, reset with the arbiter, optional forced valid
    logic [L-1:0] pv = '0;
    logic [W-1:0] py [L];
    always @(posedge clk) begin
        if (!rst) pv <= '0;
        else begin
            pv[0] <= bus.sq_x_vld;
            py[0] <= isqrt(bus.sq_x);
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                py[i] <= py[i-1];
            end
        end
    end
    assign bus.sq_y_vld = pv[L-1] | force_vld;
    assign bus.sq_y = py[L-1];
    // Transaction model: grant by pointer search, responses scheduled L+2 cycles after handshake
    int m_ptr = 0;
    int cyc = 0;
    int mg;
    logic dv [64];
    int did [64];
    logic [W-1:0] dy [64];
    int iss_q [$];
    logic e_sq_vld = 1'b0;
    logic [W-1:0] e_sq_x = '0;
    logic [N-1:0] e_rsp_vld = '0;
    logic [W-1:0] e_rsp_y = '0;
    int e_rsp_id = 0;
    logic e_err = 1'b0;
    initial foreach (dv[i]) dv[i] = 1'b0;
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_ptr = 0;
            e_sq_vld = 1'b0;
            e_sq_x = '0;
            e_rsp_vld = '0;
            e_rsp_y = '0;
            e_rsp_id = 0;
            e_err = 1'b0;
            iss_q.delete();
            foreach (dv[i]) dv[i] = 1'b0;
        end else begin
            mg = pick(bus.req_vld, m_ptr);
            if (force_vld && !dv[cyc % 64]) e_err = 1'b1;
            e_rsp_vld = '0;
            if (dv[cyc % 64]) begin
                e_rsp_vld = N'(1) << did[cyc % 64];
                e_rsp_y = dy[cyc % 64];
                e_rsp_id = did[cyc % 64];
                dv[cyc % 64] = 1'b0;
            end
            e_sq_vld = (mg >= 0);
            if (mg >= 0) begin
                e_sq_x = bus.req_x[mg*W +: W];
                m_ptr = (mg + 1) % N;
                dv[(cyc - 1 + L + 2) % 64] = 1'b1;
                did[(cyc - 1 + L + 2) % 64] = mg;
                dy[(cyc - 1 + L + 2) % 64] = isqrt(e_sq_x);
                iss_q.push_back(cyc - 1);
            end
            while (iss_q.size() > 0 && iss_q[0] + L + 2 < cyc) void'(iss_q.pop_front());
        end
    end
    int cg;
    logic [N-1:0] e_rdy;
    always @(negedge clk) begin
        if (chk_en) begin
            cg = pick(bus.req_vld, m_ptr);
            e_rdy = (rst && cg >= 0) ? N'(1) << cg : '0;
            chk("req_rdy", 64'(bus.req_rdy), 64'(e_rdy));
            chk("sq_x_vld", 64'(bus.sq_x_vld), 64'(e_sq_vld));
            chk("sq_x", 64'(bus.sq_x), 64'(e_sq_x));
            chk("rsp_vld", 64'(bus.rsp_vld), 64'(e_rsp_vld));
            chk("rsp_y", 64'(bus.rsp_y), 64'(e_rsp_y));
            chk("rsp_id", 64'(bus.rsp_id), 64'(e_rsp_id));
            chk("in_flight", 64'(bus.in_flight), 64'(iss_q.size()));
            chk("tag_err", 64'(bus.tag_err), 64'(e_err));
        end
    end
    task automatic step(input logic [N-1:0] v);
        @(posedge clk);
        #2;
        bus.req_vld = v;
    endtask
    task automatic rand_x();
        for (int i = 0; i < N; i++) bus.req_x[i*W +: W] = $urandom;
    endtask
    logic seen;
    initial begin
        bus.req_vld = '1;
        bus.req_x = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("t1_rdy_in_reset", 64'(bus.req_rdy), 64'(0));
        chk("t1_in_flight", 64'(bus.in_flight), 64'(0));
        chk("t1_sq_x_vld", 64'(bus.sq_x_vld), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.req_vld = '0;
        bus.req_x = {32'd49, 32'd36, 32'd25, 32'd16};
        for (int k = 0; k < 8; k++) begin
            step(4'b1111);
            #3 chk("t3_grant", 64'(bus.req_rdy), 64'(N'(1) << (k % N)));
        end
        step('0);
        #3;
        repeat (2) @(negedge clk);
        chk("t3_rsp_y0", 64'(bus.rsp_y), 64'(4));
        chk("t3_rsp_id0", 64'(bus.rsp_id), 64'(0));
        repeat (3) @(negedge clk);
        chk("t3_rsp_y3", 64'(bus.rsp_y), 64'(7));
        chk("t3_rsp_vld3", 64'(bus.rsp_vld), 64'(4'b1000));
        repeat (15) @(negedge clk);
        bus.req_x[2*W +: W] = 81;
        step(4'b0100);
        #3 chk("t2_rdy", 64'(bus.req_rdy), 64'(4'b0100));
        step('0);
        #3;
        chk("t2_sq_x_vld", 64'(bus.sq_x_vld), 64'(1));
        chk("t2_sq_x", 64'(bus.sq_x), 64'(81));
        repeat (9) @(negedge clk);
        chk("t2_rsp_vld", 64'(bus.rsp_vld), 64'(4'b0100));
        chk("t2_rsp_y", 64'(bus.rsp_y), 64'(9));
        chk("t2_rsp_id", 64'(bus.rsp_id), 64'(2));
        step(4'b0011);
        #3 chk("t4_grant_a", 64'(bus.req_rdy), 64'(4'b0001));
        step(4'b0011);
        #3 chk("t4_grant_b", 64'(bus.req_rdy), 64'(4'b0010));
        step(4'b0011);
        #3 chk("t4_grant_c", 64'(bus.req_rdy), 64'(4'b0001));
        step('0);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2 force_vld = 1'b1;
        @(posedge clk);
        #2 force_vld = 1'b0;
        #3;
        chk("t5_tag_err", 64'(bus.tag_err), 64'(1));
        chk("t5_rsp_vld", 64'(bus.rsp_vld), 64'(0));
        repeat (4) @(negedge clk);
        chk("t5_sticky", 64'(bus.tag_err), 64'(1));
        for (int k = 0; k < 5; k++) begin
            rand_x();
            step(4'b1111);
        end
        @(posedge clk);
        #2;
        bus.req_vld = '0;
        rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #3;
        chk("t6_in_flight", 64'(bus.in_flight), 64'(0));
        chk("t6_tag_err", 64'(bus.tag_err), 64'(0));
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | (|bus.rsp_vld);
        end
        chk("t6_no_rsp", 64'(seen), 64'(0));
        for (int k = 0; k < 15; k++) begin
            rand_x();
            step(4'b1111);
        end
        #3 chk("sustained_in_flight", 64'(bus.in_flight), 64'(10));
        for (int k = 0; k < 400; k++) begin
            rand_x();
            step(($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom));
        end
        step('0);
        repeat (15) @(negedge clk);
        chk("drained", 64'(bus.in_flight), 64'(0));
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
